// File: rtl/data_register.sv
// Single WIDTH-bit capture register loaded when the controller sits in LOAD_STATE.
// Optional feature: define DATA_REGISTER_VALID_EN to add a sticky dr_valid flag.
module data_register #(
    parameter int                 WIDTH      = 32,
    parameter int                 STATE_W    = 3,
    parameter logic [STATE_W-1:0] LOAD_STATE = 3'd2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [STATE_W-1:0] state,
    input  logic [WIDTH-1:0]   dr_writedata,
    output logic [WIDTH-1:0]   dr_readdata
`ifdef DATA_REGISTER_VALID_EN
    ,
    output logic               dr_valid
`endif
);

    logic             load_en;
    logic [WIDTH-1:0] data_reg;

    // Every non-load encoding, including unused ones, holds the stored value.
    assign load_en = (state == LOAD_STATE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_reg <= '0;
        end else if (load_en) begin
            data_reg <= dr_writedata;
        end
    end

    assign dr_readdata = data_reg;

`ifdef DATA_REGISTER_VALID_EN
    logic valid_reg;

    // Sticky: once anything has been captured it stays set until reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_reg <= 1'b0;
        end else if (load_en) begin
            valid_reg <= 1'b1;
        end
    end

    assign dr_valid = valid_reg;
`endif

endmodule

// File: tb/tb_data_register.sv
// Self-checking bench for data_register: directed vector table, hand-written
// asynchronous/inter-edge sequences, and randomized cycles against a reference model.
module tb_data_register;

    localparam int WIDTH   = 32;
    localparam int STATE_W = 3;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic [STATE_W-1:0] state = '0;
    logic [WIDTH-1:0]   dr_writedata = '0;
    logic [WIDTH-1:0]   dr_readdata;
`ifdef DATA_REGISTER_VALID_EN
    logic               dr_valid;
`endif

    int checks = 0;
    int errors = 0;

    data_register #(
        .WIDTH(WIDTH),
        .STATE_W(STATE_W),
        .LOAD_STATE(3'd2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .state(state),
        .dr_writedata(dr_writedata),
        .dr_readdata(dr_readdata)
`ifdef DATA_REGISTER_VALID_EN
        ,
        .dr_valid(dr_valid)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic               rst;
        logic [STATE_W-1:0] st;
        logic [WIDTH-1:0]   wd;
        logic [WIDTH-1:0]   exp_rd;
        logic               exp_v;
    } vec_t;

    vec_t vecs[13];

    task automatic check_data(input string name, input logic [WIDTH-1:0] act,
                              input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_valid(input string name, input logic exp);
`ifdef DATA_REGISTER_VALID_EN
        check_bit(name, dr_valid, exp);
`endif
    endtask

    // Drive on the falling edge, then sample 1 time unit after the rising edge.
    task automatic step(input logic rst, input logic [STATE_W-1:0] st,
                        input logic [WIDTH-1:0] wd);
        @(negedge clk);
        reset        = rst;
        state        = st;
        dr_writedata = wd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [WIDTH-1:0] ref_data;
        logic             ref_valid;
        logic [WIDTH-1:0] held;

        vecs[0]  = '{1'b0, 3'd2, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1};
        vecs[1]  = '{1'b0, 3'd0, 32'h11111111, 32'hDEADBEEF, 1'b1};
        vecs[2]  = '{1'b0, 3'd1, 32'h22222222, 32'hDEADBEEF, 1'b1};
        vecs[3]  = '{1'b0, 3'd3, 32'h33333333, 32'hDEADBEEF, 1'b1};
        vecs[4]  = '{1'b0, 3'd4, 32'h44444444, 32'hDEADBEEF, 1'b1};
        vecs[5]  = '{1'b0, 3'd5, 32'h55555555, 32'hDEADBEEF, 1'b1};
        vecs[6]  = '{1'b0, 3'd7, 32'h77777777, 32'hDEADBEEF, 1'b1};
        vecs[7]  = '{1'b1, 3'd2, 32'hFFFFFFFF, 32'h00000000, 1'b0};
        vecs[8]  = '{1'b0, 3'd6, 32'h12345678, 32'h00000000, 1'b0};
        vecs[9]  = '{1'b0, 3'd2, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b1};
        vecs[10] = '{1'b0, 3'd2, 32'h00000001, 32'h00000001, 1'b1};
        vecs[11] = '{1'b0, 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1};
        vecs[12] = '{1'b0, 3'd7, 32'h00000000, 32'hFFFFFFFF, 1'b1};

        // Reset asserted before any clock edge must clear the output on its own.
        #2;
        reset = 1'b1;
        state = 3'd2;
        dr_writedata = 32'hCAFEF00D;
        #1;
        check_data("async_reset_no_clock", dr_readdata, '0);
        check_valid("async_reset_no_clock_valid", 1'b0);
        step(1'b1, 3'd2, 32'hCAFEF00D);
        check_data("reset_holds_over_edge", dr_readdata, '0);

        for (int i = 0; i < 13; i++) begin
            step(vecs[i].rst, vecs[i].st, vecs[i].wd);
            $display("vec %0d: rst=%b st=%0d wd=%h rd=%h exp=%h", i, vecs[i].rst,
                     vecs[i].st, vecs[i].wd, dr_readdata, vecs[i].exp_rd);
            check_data($sformatf("vec%0d_data", i), dr_readdata, vecs[i].exp_rd);
            check_valid($sformatf("vec%0d_valid", i), vecs[i].exp_v);
        end

        // Input changes between edges must not leak to the output.
        step(1'b0, 3'd2, 32'h0BADC0DE);
        check_data("load_before_glitch", dr_readdata, 32'h0BADC0DE);
        #1;
        state = 3'd2;
        dr_writedata = 32'h99999999;
        #2;
        check_data("no_comb_path", dr_readdata, 32'h0BADC0DE);
        state = 3'd0;
        @(posedge clk);
        #1;
        check_data("glitch_not_captured", dr_readdata, 32'h0BADC0DE);

        // Mid-cycle reset discards data immediately, without a clock edge.
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_data("mid_cycle_reset", dr_readdata, '0);
        check_valid("mid_cycle_reset_valid", 1'b0);
        step(1'b0, 3'd3, 32'h5A5A5A5A);
        check_data("post_reset_hold_zero", dr_readdata, '0);

        // Randomized cycles against a rule-level model.
        ref_data  = '0;
        ref_valid = 1'b0;
        for (int c = 0; c < 100; c++) begin
            logic               r_rst;
            logic [STATE_W-1:0] r_st;
            logic [WIDTH-1:0]   r_wd;
            r_rst = ($urandom_range(99) == 0);
            r_st  = STATE_W'($urandom_range(5));
            r_wd  = $urandom;
            held  = ref_data;
            if (r_rst) begin
                ref_data  = '0;
                ref_valid = 1'b0;
            end else if (r_st == 3'd2) begin
                ref_data  = r_wd;
                ref_valid = 1'b1;
            end else begin
                ref_data = held;
            end
            step(r_rst, r_st, r_wd);
            $display("rnd %0d: rst=%b st=%0d wd=%h rd=%h exp=%h", c, r_rst, r_st, r_wd,
                     dr_readdata, ref_data);
            check_data($sformatf("rnd%0d_data", c), dr_readdata, ref_data);
            check_valid($sformatf("rnd%0d_valid", c), ref_valid);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
